// File: rtl/fsm_ctx_pkg.sv
// Shared types and the toggle-flip-flop core step for the context arbiter.
// The step function is also used by the bench model.
package fsm_ctx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        STORE = 2'd3
    } ctrl_state_t;

    // state = {FA, FB}; FA is driven by TA = FA^x, FB by TB = ~FA & x
    function automatic logic [1:0] tff_step(input logic [1:0] state, input logic x);
        logic ta;
        logic tb;
        ta = state[1] ^ x;
        tb = ~state[1] & x;
        return {state[1] ^ ta, state[0] ^ tb};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr,
// wrapping past NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            hit
);

    always_comb begin
        int j;
        idx = '0;
        hit = 1'b0;
        j   = 0;
        // Scan farthest-first so the closest candidate to ptr overwrites last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req_valid[j]) begin
                idx = IW'(j);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_ctx_arbiter.sv
// Time-shares one 2-bit TFF core among NREQ bit-serial requesters, saving and
// restoring each requester's context around round-robin grants.
module fsm_ctx_arbiter
    import fsm_ctx_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_bit,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    output logic [$clog2(NREQ)-1:0]  out_id,
    output logic [1:0]               out_state,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    ctrl_state_t            state;
    ctrl_state_t            state_nxt;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_hit;
    logic [NREQ-1:0][1:0]   ctx;
    logic [1:0]             core;
    logic [1:0]             core_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   ended_last;
    logic                   accept;
    logic                   last_bit;
    logic                   burst_done;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .idx       (pick_idx),
        .hit       (pick_hit)
    );

    assign accept     = (state == RUN) && req_valid[gnt];
    assign core_nxt   = tff_step(core, req_bit[gnt]);
    assign cnt_nxt    = cnt + CW'(1);
    assign last_bit   = accept && req_last[gnt];
    assign burst_done = accept && (cnt_nxt == CW'(BURST));
    assign busy       = (state != IDLE);

    // Ready comes only from registered state and grant, never from req_*.
    always_comb begin
        req_ready = '0;
        if (state == RUN) req_ready[gnt] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_hit) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (!req_valid[gnt] || last_bit || burst_done) state_nxt = STORE;
            STORE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            gnt        <= '0;
            ctx        <= '0;
            core       <= '0;
            cnt        <= '0;
            ended_last <= 1'b0;
            out_valid  <= 1'b0;
            out_id     <= '0;
            out_state  <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_id    <= gnt;
                out_state <= core_nxt;
                core      <= core_nxt;
                cnt       <= cnt_nxt;
                if (req_last[gnt]) ended_last <= 1'b1;
            end
            case (state)
                IDLE:  if (pick_hit) gnt <= pick_idx;
                LOAD: begin
                    core       <= ctx[gnt];
                    cnt        <= '0;
                    ended_last <= 1'b0;
                end
                STORE: begin
                    // A finished stream leaves a clean context for its next one.
                    ctx[gnt] <= ended_last ? 2'b00 : core;
                    ptr      <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_ctx_arbiter.sv
// Directed bench for fsm_ctx_arbiter: per-requester bit queues feed the DUT,
// observed output beats are logged and compared against hand-computed values.
module tb_fsm_ctx_arbiter;

    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NREQ-1:0]  req_valid = '0;
    logic [NREQ-1:0]  req_bit = '0;
    logic [NREQ-1:0]  req_last = '0;
    logic [NREQ-1:0]  req_ready;
    logic             out_valid;
    logic [1:0]       out_id;
    logic [1:0]       out_state;
    logic             busy;

    fsm_ctx_arbiter #(.NREQ(NREQ), .BURST(BURST)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int id;
        int st;
        int t;
    } obs_t;

    int         cyc = 0;
    int         nvec = 0;
    int         nmis = 0;
    logic [1:0] srcq [NREQ][$];   // {last, bit} per requester
    obs_t       log_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic l, input logic b);
        srcq[i].push_back({l, b});
    endtask

    task automatic sync();
        @(posedge clock);
        #2;
    endtask

    function automatic logic pending();
        logic p;
        p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((busy || pending()) && n < 200);
        chk({tag, " idle timeout"}, n >= 200, 0);
    endtask

    task automatic expect_out(input string tag, input int id, input int st, output int t);
        obs_t o;
        t = -1;
        chk({tag, " present"}, log_q.size() > 0, 1);
        if (log_q.size() > 0) begin
            o = log_q.pop_front();
            chk({tag, " id"}, o.id, id);
            chk({tag, " state"}, o.st, st);
            t = o.t;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, tp, t0, n;
        int rr_id[8];

        fork
            forever begin
                @(negedge clock);
                for (int i = 0; i < NREQ; i++) begin
                    logic [1:0] h;
                    h = 2'b00;
                    if (srcq[i].size() > 0) h = srcq[i][0];
                    req_valid[i] = (srcq[i].size() > 0);
                    req_bit[i]   = h[0];
                    req_last[i]  = h[1];
                end
            end
            forever begin
                @(posedge clock);
                #1;
                if (out_valid) begin
                    log_q.push_back('{int'(out_id), int'(out_state), cyc});
                    if (srcq[out_id].size() > 0) void'(srcq[out_id].pop_front());
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst req_ready", req_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_id", out_id, 0);
        chk("rst out_state", out_state, 0);
        chk("rst busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        // Single stream on req0 from ctx 00: 0,1,1,0(last) -> 00,11,11,01
        sync();
        t0 = cyc;
        push(0, 0, 0); push(0, 0, 1); push(0, 0, 1); push(0, 1, 0);
        wait_idle("t1");
        expect_out("t1 b0", 0, 0, t);
        chk("t1 first latency", t - t0, 3);
        expect_out("t1 b1", 0, 3, tp);
        chk("t1 b1 spacing", tp - t, 1);
        expect_out("t1 b2", 0, 3, t);
        expect_out("t1 b3", 0, 1, t);
        // ctx[0] cleared by last: 00 with x=1 -> 11
        sync();
        push(0, 1, 1);
        wait_idle("t1c");
        expect_out("t1 ctx clear", 0, 3, t);

        // Context preservation (ptr=1 now, only req0 valid)
        sync();
        push(0, 0, 1); push(0, 0, 1);
        wait_idle("t2a");
        expect_out("t2 r0 b0", 0, 3, t);
        expect_out("t2 r0 b1", 0, 3, t);
        sync();
        push(1, 0, 1);
        wait_idle("t2b");
        expect_out("t2 r1 b0", 1, 3, t);
        sync();
        push(0, 1, 0);   // restored 11, x=0 -> 01
        wait_idle("t2c");
        expect_out("t2 r0 resume", 0, 1, t);

        // Round-robin: all four valid, one bit per grant (ptr=1 here)
        sync();
        for (int i = 0; i < NREQ; i++) begin
            push(i, 1, 1);
            push(i, 1, 1);
        end
        wait_idle("t3");
        rr_id = '{1, 2, 3, 0, 1, 2, 3, 0};
        tp = -1;
        for (int k = 0; k < 8; k++) begin
            expect_out($sformatf("t3 grant%0d", k), rr_id[k], 3, t);
            if (k > 0) chk($sformatf("t3 spacing%0d", k), t - tp, 4);
            tp = t;
        end

        // Valid gap on req2: 1,0 then valid low -> partial ctx 01 kept
        sync();
        push(2, 0, 1); push(2, 0, 0);
        @(posedge clock); #1;
        chk("t4 load ready", req_ready, 0);
        chk("t4 load busy", busy, 1);
        @(posedge clock); #1;
        chk("t4 run ready", req_ready, 4'b0100);
        wait_idle("t4");
        chk("t4 beat count", log_q.size(), 2);
        expect_out("t4 b0", 2, 3, t);
        expect_out("t4 b1", 2, 1, t);
        sync();
        push(2, 1, 1);   // 01 with x=1 -> 10
        wait_idle("t4b");
        expect_out("t4 resume", 2, 2, t);

        // Reset in mid-grant: leave ctx0=11 first, then abort req3 after 2 bits
        sync();
        push(0, 0, 1);
        wait_idle("t5a");
        expect_out("t5 r0 pre", 0, 3, t);
        sync();
        push(3, 0, 1); push(3, 0, 1); push(3, 0, 1); push(3, 0, 1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (log_q.size() < 2 && n < 50);
        chk("t5 wait timeout", n >= 50, 0);
        reset = 1'b1;
        srcq[3].delete();
        @(posedge clock); #1;
        chk("t5 rst out_valid", out_valid, 0);
        chk("t5 rst out_id", out_id, 0);
        chk("t5 rst out_state", out_state, 0);
        chk("t5 rst busy", busy, 0);
        chk("t5 rst req_ready", req_ready, 0);
        expect_out("t5 r3 b0", 3, 3, t);
        expect_out("t5 r3 b1", 3, 3, t);
        chk("t5 no extra beat", log_q.size(), 0);
        @(negedge clock);
        reset = 1'b0;
        // ptr back to 0 -> req0 first; ctx0 cleared: 00,x=0 -> 00; ctx3: 00,x=1 -> 11
        sync();
        push(0, 1, 0); push(3, 1, 1);
        wait_idle("t5b");
        expect_out("t5 r0 post", 0, 0, t);
        expect_out("t5 r3 post", 3, 3, t);

        // req_last on the BURST-th bit (ptr=0): 1,0,1,1(last) -> 11,01,10,10
        sync();
        push(1, 0, 1); push(1, 0, 0); push(1, 0, 1); push(1, 1, 1);
        wait_idle("t6");
        chk("t6 beat count", log_q.size(), 4);
        expect_out("t6 b0", 1, 3, t);
        expect_out("t6 b1", 1, 1, t);
        expect_out("t6 b2", 1, 2, t);
        expect_out("t6 b3", 1, 2, tp);
        chk("t6 single grant", tp - t, 1);
        // ptr now 2 -> order 3,0,1; ctx1 cleared -> 11
        sync();
        push(0, 1, 1); push(1, 1, 1); push(3, 1, 1);
        wait_idle("t6b");
        expect_out("t6 next r3", 3, 3, t);
        expect_out("t6 next r0", 0, 3, t);
        expect_out("t6 next r1", 1, 3, t);

        // Burst limit without last on req2: 1,0,1,0 | 1(last) -> 11,01,10,00 | 11
        sync();
        push(2, 0, 1); push(2, 0, 0); push(2, 0, 1); push(2, 0, 0); push(2, 1, 1);
        wait_idle("t7");
        expect_out("t7 b0", 2, 3, t);
        expect_out("t7 b1", 2, 1, t);
        expect_out("t7 b2", 2, 2, t);
        expect_out("t7 b3", 2, 0, tp);
        expect_out("t7 b4", 2, 3, t);
        chk("t7 regrant gap", t - tp, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/fsm_ctx_arbiter.md
# fsm_ctx_arbiter

Time-shares one 2-bit toggle-flip-flop state machine core among NREQ serial-bit requesters. Each requester keeps its own saved 2-bit context. The block arbitrates round-robin, loads the winner's context into the core, and steps the core once per accepted bit. It then writes the context back. It sits between independent bit-stream sources and the shared FSM datapath, and reports every state update on a single output stream.

## Interface
- NREQ, 4: number of requesters (2..8)
- BURST, 4: maximum bits accepted per grant (1..15)
- clock  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  requester i has a bit pending
- req_bit  in  NREQ  bit (x_in) of requester i
- req_last  in  NREQ  bit of requester i ends its stream; its context clears after use
- req_ready  out  NREQ  one-hot or zero; acceptance = req_valid[i] & req_ready[i]
- out_valid  out  1  one-cycle pulse per accepted bit
- out_id  out  $clog2(NREQ)  requester whose bit produced out_state
- out_state  out  2  new {FA,FB} after the accepted bit
- busy  out  1  controller not in IDLE

## Operation
- Core transition (per accepted bit x): TA = FA^x, TB = ~FA & x; FA' = FA^TA (= x); FB' = FB^TB.
- Context array ctx[NREQ] of 2 bits, all 00 after reset.
- Controller states: IDLE, LOAD, RUN, STORE.
- IDLE: if any req_valid, grant the first i at or after ptr (wrapping), go to LOAD. Otherwise stay.
- LOAD: core <= ctx[g]; cnt <= 0; req_ready all 0. Go to RUN.
- RUN: req_ready[g] = 1. On acceptance, core steps with req_bit[g] and cnt increments.
- RUN exits to STORE when any of these holds:
  - An accepted bit has req_last = 1.
  - An accepted bit makes cnt reach BURST.
  - req_valid[g] = 0 in a RUN cycle; no acceptance occurs that cycle.
- STORE: ctx[g] <= core, or 00 if the grant ended on req_last. ptr <= g+1 mod NREQ. Go to IDLE.
- Requesters not granted never see req_ready; their ctx is untouched.
- Within a grant, req_bit and req_last are sampled only on acceptance cycles.

## Timing
- Reset values: state IDLE, ptr 0, ctx all 00, core 00, cnt 0, req_ready 0, out_valid 0, out_id 0, out_state 00, busy 0.
- Reset asserted mid-grant: all in-flight bits and unsaved core state are discarded. Next cycle is IDLE with reset values.
- Grant overhead: IDLE→LOAD→first RUN cycle. The first acceptance is possible 2 cycles after IDLE sees req_valid.
- Throughput in RUN: one bit per cycle.
- Minimum cost per grant: 4 cycles (IDLE, LOAD, ≥1 RUN, STORE).
- Output latency: out_valid/out_id/out_state are registered, 1 cycle after the acceptance edge.
- out_state equals the core value after the step.
- req_last with cnt = BURST-1 on the same bit: a single exit; ctx is cleared to 00.
- ptr wraps from NREQ-1 to 0.
- A requester that deasserts during RUN loses its grant and keeps its partial context.
- No combinational path from req_* to req_ready; req_ready depends only on registered state.

## Structure
- Package fsm_ctx_pkg holds:
  - ctrl_state_t enum (IDLE, LOAD, RUN, STORE).
  - A function tff_step(state[1:0], x) returning the next {FA,FB}, shared with the bench model.
- One sub-module, rr_pick: combinational round-robin selector taking req_valid and ptr, returning index and hit.
- Context array and core registers are in the top.

## Test plan
- Single requester 0, ctx 00, bits 0,1,1,0 (last on 4th), BURST=4 → out_state 00,11,11,01 with out_id 0. Then ctx[0] = 00.
- Context preservation, BURST=2:
  - Req0 sends 1,1 → states 11,11; ctx[0]=11.
  - Req1 sends 1 → state 11, then drops valid.
  - Req0 resumes with 0 → out_state 01 (restored from 11, not 00).
- Round-robin with all four requesters valid continuously and BURST=1 → grants 0,1,2,3,0 in order. Each grant is 4 cycles; out_valid occurs once per grant.
- Valid gap: req2 valid for 2 bits, then low in RUN → STORE with ctx[2] holding the partial state. No out_valid for the gap cycle.
- Reset asserted during RUN after 2 accepted bits → next cycle IDLE, all outputs 0, ctx all 00. A subsequent bit 1 from ctx 00 yields out_state 11.
- req_last on the BURST-th bit → a single STORE, ctx cleared to 00, ptr advanced by one.
